// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - skewed operand feeder for a SIZE x SIZE systolic array
//
// Captures matrices A and B on i_start and streams them into the array edges
// with a one-step skew per lane, so PE(i,j) sees A[i][s] and B[s][j] together.
//
// Ports
//   i_clock        : clock, rising edge
//   i_reset        : asynchronous active-high reset
//   i_start        : load i_a_mat / i_b_mat and start one feed (IDLE only)
//   i_a_mat        : matrix A, A[r][c] at [(r*SIZE+c)*I_BITS +: I_BITS]
//   i_b_mat        : matrix B, same packing
//   o_a_full       : A lanes (row inputs), lane k at [k*I_BITS +: I_BITS]
//   o_b_full       : B lanes (column inputs), same packing
//   o_array_reset  : accumulator clear pulse, high during CLEAR
//   o_busy         : high during CLEAR and FEED
//   o_done         : one-cycle pulse in DONE
module systolic_skew_feeder #(
  parameter int SIZE   = 4,
  parameter int I_BITS = 8
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [SIZE*SIZE*I_BITS-1:0] i_a_mat,
  input  logic [SIZE*SIZE*I_BITS-1:0] i_b_mat,
  output logic [SIZE*I_BITS-1:0]      o_a_full,
  output logic [SIZE*I_BITS-1:0]      o_b_full,
  output logic                        o_array_reset,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int M_BITS = SIZE*SIZE*I_BITS;
  localparam int L_BITS = SIZE*I_BITS;
  localparam int T_BITS = $clog2(2*SIZE);
  // FEED steps 0..2*SIZE-2 carry data; step 2*SIZE-1 is an all-zero drain
  // step that keeps the array busy while the last skewed element lands.
  localparam logic [T_BITS-1:0] T_LAST = T_BITS'(2*SIZE-1);

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [T_BITS-1:0]   r_t;
  logic [T_BITS-1:0]   w_t_nxt;
  logic                w_load;
  logic [M_BITS-1:0]   r_a_mat;
  logic [M_BITS-1:0]   r_b_mat;
  logic [L_BITS-1:0]   w_a_lanes;
  logic [L_BITS-1:0]   w_b_lanes;

  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        w_t_nxt = '0;
        if (i_start) begin
          w_state_nxt = CLEAR;
          w_load      = 1'b1;
        end
      end
      CLEAR: begin
        w_state_nxt = FEED;
        w_t_nxt     = '0;
      end
      FEED: begin
        if (r_t == T_LAST) begin
          w_state_nxt = DONE;
          w_t_nxt     = '0;
        end else begin
          w_t_nxt = r_t + 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_t_nxt     = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_t_nxt     = '0;
      end
    endcase
  end

  // Lanes are computed from the next state/step so that the registered
  // outputs line up with the state they describe.
  always_comb begin
    w_a_lanes = '0;
    w_b_lanes = '0;
    if (w_state_nxt == FEED) begin
      for (int k = 0; k < SIZE; k++) begin
        if ((int'(w_t_nxt) >= k) && (int'(w_t_nxt) - k < SIZE)) begin
          w_a_lanes[k*I_BITS +: I_BITS] =
            r_a_mat[(k*SIZE + int'(w_t_nxt) - k)*I_BITS +: I_BITS];
          w_b_lanes[k*I_BITS +: I_BITS] =
            r_b_mat[((int'(w_t_nxt) - k)*SIZE + k)*I_BITS +: I_BITS];
        end
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_t           <= '0;
      r_a_mat       <= '0;
      r_b_mat       <= '0;
      o_a_full      <= '0;
      o_b_full      <= '0;
      o_array_reset <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
      if (w_load) begin
        r_a_mat <= i_a_mat;
        r_b_mat <= i_b_mat;
      end
      o_a_full      <= w_a_lanes;
      o_b_full      <= w_b_lanes;
      o_array_reset <= (w_state_nxt == CLEAR);
      o_busy        <= (w_state_nxt == CLEAR) || (w_state_nxt == FEED);
      o_done        <= (w_state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - self-checking bench for systolic_skew_feeder
module tb_systolic_skew_feeder;

  localparam int S = 4;
  localparam int W = 8;

  logic             i_clock = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_start = 1'b0;
  logic [S*S*W-1:0] i_a_mat = '0;
  logic [S*S*W-1:0] i_b_mat = '0;
  logic [S*W-1:0]   o_a_full;
  logic [S*W-1:0]   o_b_full;
  logic             o_array_reset;
  logic             o_busy;
  logic             o_done;

  systolic_skew_feeder #(.SIZE(S), .I_BITS(W)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_a_mat       (i_a_mat),
    .i_b_mat       (i_b_mat),
    .o_a_full      (o_a_full),
    .o_b_full      (o_b_full),
    .o_array_reset (o_array_reset),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 i_clock = ~i_clock;

  int n_cmp = 0;
  int n_err = 0;
  int ma [S][S];
  int mb [S][S];

  // Downstream output-stationary array used for the end-to-end check.
  logic [W-1:0] pa  [S][S];
  logic [W-1:0] pb  [S][S];
  int           acc [S][S];

  function automatic logic [W-1:0] a_in(int i, int j);
    if (j == 0) return o_a_full[i*W +: W];
    return pa[i][j-1];
  endfunction

  function automatic logic [W-1:0] b_in(int i, int j);
    if (i == 0) return o_b_full[j*W +: W];
    return pb[i-1][j];
  endfunction

  always @(posedge i_clock) begin
    for (int i = 0; i < S; i++) begin
      for (int j = 0; j < S; j++) begin
        pa[i][j]  <= a_in(i, j);
        pb[i][j]  <= b_in(i, j);
        acc[i][j] <= o_array_reset ? 0 : acc[i][j] + int'(a_in(i, j)) * int'(b_in(i, j));
      end
    end
  end

  typedef struct {
    int          j;
    logic [31:0] a;
    logic [31:0] b;
    logic        rst;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive_mats();
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        i_a_mat[(r*S+c)*W +: W] = ma[r][c][W-1:0];
        i_b_mat[(r*S+c)*W +: W] = mb[r][c][W-1:0];
      end
  endtask

  // Reference: cycle j after the sampling edge. j=1 CLEAR, j=2..8 data steps
  // t=j-2, j=9 drain step, j=10 DONE, j=11 IDLE.
  function automatic logic [31:0] mdl_a(int j);
    logic [31:0] v = '0;
    int t = j - 2;
    if (t >= 0 && t <= 2*S-2)
      for (int k = 0; k < S; k++)
        if (t - k >= 0 && t - k < S) v[k*W +: W] = ma[k][t-k][W-1:0];
    return v;
  endfunction

  function automatic logic [31:0] mdl_b(int j);
    logic [31:0] v = '0;
    int t = j - 2;
    if (t >= 0 && t <= 2*S-2)
      for (int k = 0; k < S; k++)
        if (t - k >= 0 && t - k < S) v[k*W +: W] = mb[t-k][k][W-1:0];
    return v;
  endfunction

  task automatic check_cycle(input string tag, input int j);
    chk($sformatf("%s_j%0d_a", tag, j), o_a_full, mdl_a(j));
    chk($sformatf("%s_j%0d_b", tag, j), o_b_full, mdl_b(j));
    chk($sformatf("%s_j%0d_rst", tag, j), 32'(o_array_reset), 32'(j == 1));
    chk($sformatf("%s_j%0d_busy", tag, j), 32'(o_busy), 32'(j >= 1 && j <= 2*S+1));
    chk($sformatf("%s_j%0d_done", tag, j), 32'(o_done), 32'(j == 2*S+2));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a"}, o_a_full, 32'd0);
    chk({tag, "_b"}, o_b_full, 32'd0);
    chk({tag, "_rst"}, 32'(o_array_reset), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
  endtask

  task automatic run_check(input string tag);
    drive_mats();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int j = 1; j <= 2*S+3; j++) begin
      if (j > 1) step();
      check_cycle(tag, j);
    end
  endtask

  task automatic rand_mats();
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        ma[r][c] = int'($urandom_range(0, 255));
        mb[r][c] = int'($urandom_range(0, 255));
      end
  endtask

  task automatic e2e(input string tag);
    int exp_c;
    logic nz;
    drive_mats();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    nz = 1'b0;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        if (acc[i][j] != 0) nz = 1'b1;
    chk({tag, "_acc_clear"}, 32'(nz), 32'd0);
    for (int c = 0; c < 4*S; c++) step();
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        exp_c = 0;
        for (int s = 0; s < S; s++) exp_c += ma[i][s] * mb[s][j];
        chk($sformatf("%s_c%0d%0d", tag, i, j), 32'(acc[i][j]), 32'(exp_c));
      end
  endtask

  initial begin
    tbl[0]  = '{1,  32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{2,  32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{3,  32'h00000502, 32'h00000000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{4,  32'h00090603, 32'h00000100, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{5,  32'h0d0a0704, 32'h00000000, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{6,  32'h0e0b0800, 32'h00010000, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{7,  32'h0f0c0000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{8,  32'h10000000, 32'h01000000, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{9,  32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{10, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{11, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        pa[i][j] = '0;
        pb[i][j] = '0;
        acc[i][j] = 0;
      end

    // Reset state
    #1;
    check_zero("reset");
    step();
    step();
    check_zero("reset_held");

    // Basic run, start accepted on the first edge after release
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        ma[r][c] = r*S + c + 1;
        mb[r][c] = (r == c) ? 1 : 0;
      end
    drive_mats();
    i_reset = 1'b0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) step();
      chk($sformatf("tbl%0d_a", tbl[i].j), o_a_full, tbl[i].a);
      chk($sformatf("tbl%0d_b", tbl[i].j), o_b_full, tbl[i].b);
      chk($sformatf("tbl%0d_rst", tbl[i].j), 32'(o_array_reset), 32'(tbl[i].rst));
      chk($sformatf("tbl%0d_busy", tbl[i].j), 32'(o_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", tbl[i].j), 32'(o_done), 32'(tbl[i].done));
    end

    // Randomized runs with random idle gaps
    for (int n = 0; n < 4; n++) begin
      rand_mats();
      run_check($sformatf("rand%0d", n));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        step();
        check_zero("gap");
      end
    end

    // i_start and matrix changes ignored while busy
    rand_mats();
    drive_mats();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int j = 1; j <= 2*S+3; j++) begin
      if (j > 1) step();
      check_cycle("busyign", j);
      if (j == 4) begin
        i_start = 1'b1;
        i_a_mat = '1;
      end
      if (j == 5) i_start = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      check_zero("busyign_after");
    end

    // Continuous start: period 2*SIZE+3
    rand_mats();
    drive_mats();
    i_start = 1'b1;
    step();
    for (int c = 1; c <= 3*(2*S+3); c++) begin
      if (c > 1) step();
      check_cycle("cont", ((c - 1) % (2*S+3)) + 1);
    end
    i_start = 1'b0;
    step();
    check_zero("cont_end");

    // Reset at FEED step 3 aborts the run
    rand_mats();
    drive_mats();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int j = 2; j <= 5; j++) step();
    check_cycle("prerst", 5);
    #2;
    i_reset = 1'b1;
    #1;
    check_zero("midrst");
    step();
    i_reset = 1'b0;
    for (int c = 0; c < 2*S+4; c++) begin
      step();
      check_zero("postrst");
    end
    rand_mats();
    run_check("afterrst");

    // End-to-end through a downstream array model
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        ma[r][c] = 2;
        mb[r][c] = 2;
      end
    e2e("e2e_two");
    rand_mats();
    e2e("e2e_rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
